// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the odd-even transposition sorter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  // Phase counter must hold values 0..n so the last phase index n-1 is
  // reachable for any legal even lane count.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sort_oet_if.sv
// Valid/ready vector bus between producer, sorter and consumer.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry backpressure in each direction.
interface sort_oet_if #(
  parameter int N = 4,
  parameter int W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_data;
  logic           in_desc;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] out_data;

  // Environment side: produces input vectors and consumes sorted ones.
  modport master (
    output in_valid, in_data, in_desc, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Sorter side.
  modport slave (
    input  in_valid, in_data, in_desc, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/cmp_swap.sv
// Compare-exchange of one lane pair; lo goes to the lower lane index.
// Latency: purely combinational.
// Backpressure: none.
module cmp_swap #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         desc,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);
  logic swap;

  // Strict compares only, so equal keys never trade places (stable sort).
  always_comb begin
    swap = desc ? (a < b) : (a > b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end
endmodule

// File: rtl/sort_oet.sv
// Sorts N unsigned W-bit lanes, one odd-even transposition phase per clock.
// Latency: N cycles from acceptance to out_valid, independent of data.
// Backpressure: holds the result in DONE until out_ready; in_ready only in IDLE or DONE&out_ready.
module sort_oet
  import sort_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic       clk,
  input  logic       rst,
  sort_oet_if.slave  bus
);
  localparam int CW = cnt_w(N);
  localparam int NP = N / 2;

  sort_state_t            state_q;
  logic [N-1:0][W-1:0]    lane_q;
  logic [N-1:0][W-1:0]    lane_nxt;
  logic                   desc_q;
  logic [CW-1:0]          cnt_q;
  logic                   odd_phase;
  logic                   accept;

  logic [W-1:0] cmp_a  [NP];
  logic [W-1:0] cmp_b  [NP];
  logic [W-1:0] cmp_lo [NP];
  logic [W-1:0] cmp_hi [NP];

  assign odd_phase     = cnt_q[0];
  assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = lane_q;

  // Shared comparator bank; the pairing feeding it changes with phase parity.
  for (genvar i = 0; i < NP; i++) begin : g_cmp
    cmp_swap #(.W(W)) u_cmp (
      .a    (cmp_a[i]),
      .b    (cmp_b[i]),
      .desc (desc_q),
      .lo   (cmp_lo[i]),
      .hi   (cmp_hi[i])
    );
  end

  // Route lane pairs to comparators: even phase (0,1),(2,3)..; odd phase
  // (1,2),(3,4)..; the top comparator idles on odd phases.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      if (!odd_phase || (i == NP - 1)) begin
        cmp_a[i] = lane_q[2*i];
        cmp_b[i] = lane_q[2*i+1];
      end else begin
        cmp_a[i] = lane_q[2*i+1];
        cmp_b[i] = lane_q[(2*i+2) % N];
      end
    end
  end

  // Merge comparator results back into lane order; on odd phases lanes 0
  // and N-1 keep their values.
  always_comb begin
    lane_nxt = lane_q;
    if (!odd_phase) begin
      for (int i = 0; i < NP; i++) begin
        lane_nxt[2*i]   = cmp_lo[i];
        lane_nxt[2*i+1] = cmp_hi[i];
      end
    end else begin
      for (int i = 0; i < NP - 1; i++) begin
        lane_nxt[2*i+1] = cmp_lo[i];
        lane_nxt[2*i+2] = cmp_hi[i];
      end
    end
  end

  // Control and datapath registers: acceptance loads a fresh vector and
  // restarts the phase count, SORT applies one phase per cycle, DONE holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      desc_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= SORT;
      lane_q  <= bus.in_data;
      desc_q  <= bus.in_desc;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        SORT: begin
          lane_q <= lane_nxt;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sort_oet.sv
// Directed checks on a 4x4 sorter plus a random-traffic run on an 8x8 one.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready stalls and in_valid while busy.
module tb_sort_oet;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sort_oet_if #(.N(4), .W(4)) if4 ();
  sort_oet_if #(.N(8), .W(8)) if8 ();

  sort_oet #(.N(4), .W(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
  sort_oet #(.N(8), .W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain insertion sort on unpacked lanes.
  function automatic logic [63:0] ref_sort8(input logic [63:0] d, input logic desc);
    logic [7:0]  a [8];
    logic [7:0]  t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) a[i] = d[i*8 +: 8];
    for (int i = 1; i < 8; i++) begin
      for (int j = i; j > 0; j--) begin
        if (desc ? (a[j] > a[j-1]) : (a[j] < a[j-1])) begin
          t = a[j]; a[j] = a[j-1]; a[j-1] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  // Present a vector at posedge+1 and retire it after the accepting edge.
  task automatic accept4(input logic [15:0] d, input logic desc);
    if4.in_valid = 1'b1;
    if4.in_data  = d;
    if4.in_desc  = desc;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    if4.in_data  = '0;
    if4.in_desc  = 1'b0;
  endtask

  task automatic drain4();
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", if4.out_valid); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", if4.in_ready); end
    checks++; if (if4.out_data !== 16'h0000) begin errors++; $display("FAIL rst_out_data got %h want 0000", if4.out_data); end
    checks++; if (if8.out_valid !== 1'b0) begin errors++; $display("FAIL rst8_out_valid got %b want 0", if8.out_valid); end
    checks++; if (if8.out_data !== 64'h0) begin errors++; $display("FAIL rst8_out_data got %h want 0", if8.out_data); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_ascending();
    accept4(16'h3A17, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (if4.out_valid !== (c == 4)) begin
        errors++; $display("FAIL asc_latency cycle %0d got %b want %b", c, if4.out_valid, (c == 4));
      end
    end
    checks++; if (if4.out_data !== 16'hA731) begin errors++; $display("FAIL asc_data got %h want a731", if4.out_data); end
    checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL asc_done_in_ready got %b want 0", if4.in_ready); end
    if4.out_ready = 1'b1; #1;
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL asc_comb_in_ready got %b want 1", if4.in_ready); end
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL asc_drop_valid got %b want 0", if4.out_valid); end
  endtask

  task automatic test_descending();
    // accept4 flips in_desc back to 0 right after acceptance; the sort must ignore it.
    accept4(16'h3A17, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL desc_valid got %b want 1", if4.out_valid); end
    checks++; if (if4.out_data !== 16'h137A) begin errors++; $display("FAIL desc_data got %h want 137a", if4.out_data); end
    drain4();
  endtask

  task automatic test_worst_and_dups();
    accept4(16'h0123, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL worst_early_valid got %b want 0", if4.out_valid); end
    @(posedge clk); #1;
    checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL worst_valid got %b want 1", if4.out_valid); end
    checks++; if (if4.out_data !== 16'h3210) begin errors++; $display("FAIL worst_data got %h want 3210", if4.out_data); end
    drain4();
    accept4(16'h5525, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (if4.out_data !== 16'h5552) begin errors++; $display("FAIL dup_data got %h want 5552", if4.out_data); end
    drain4();
  endtask

  task automatic test_hold();
    accept4(16'h3A17, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      if4.in_valid = (i % 2 == 0);
      if4.in_data  = 16'h0123;
      @(posedge clk); #1;
      checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc %0d got %b want 1", i, if4.out_valid); end
      checks++; if (if4.out_data !== 16'hA731) begin errors++; $display("FAIL hold_data cyc %0d got %h want a731", i, if4.out_data); end
      checks++; if (if4.in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b want 0", i, if4.in_ready); end
    end
    if4.in_valid  = 1'b1;
    if4.in_data   = 16'h0123;
    if4.in_desc   = 1'b0;
    if4.out_ready = 1'b1;
    #1;
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", if4.in_ready); end
    @(posedge clk); #1;
    if4.in_valid  = 1'b0;
    if4.in_data   = '0;
    if4.out_ready = 1'b0;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", if4.out_valid); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL next_valid got %b want 1", if4.out_valid); end
    checks++; if (if4.out_data !== 16'h3210) begin errors++; $display("FAIL next_data got %h want 3210", if4.out_data); end
    drain4();
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    if4.out_ready = 1'b1;
    if4.in_valid  = 1'b1;
    if4.in_data   = 16'h5525;
    if4.in_desc   = 1'b0;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (if4.out_valid) begin
        seen++;
        checks++; if (if4.out_data !== 16'h5552) begin errors++; $display("FAIL b2b_data edge %0d got %h want 5552", e, if4.out_data); end
      end
    end
    checks++; if (seen !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", seen); end
    if4.in_valid = 1'b0;
    if4.in_data  = '0;
    @(posedge clk); #1;
    if4.out_ready = 1'b0;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b want 0", if4.out_valid); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got %b want 1", if4.in_ready); end
  endtask

  task automatic test_reset_mid();
    accept4(16'h3A17, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (if4.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", if4.out_valid); end
    checks++; if (if4.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", if4.in_ready); end
    checks++; if (if4.out_data !== 16'h0000) begin errors++; $display("FAIL midrst_data got %h want 0000", if4.out_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    accept4(16'h3A17, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (if4.out_valid !== 1'b1) begin errors++; $display("FAIL postrst_valid got %b want 1", if4.out_valid); end
    checks++; if (if4.out_data !== 16'hA731) begin errors++; $display("FAIL postrst_data got %h want a731", if4.out_data); end
    drain4();
  endtask

  task automatic test_random8();
    logic [63:0] exp_q [$];
    logic [63:0] want;
    logic [63:0] prev_dat;
    logic        prev_hold;
    logic        fired;
    int          sent;
    int          recv;
    int          cyc;
    sent = 0; recv = 0; cyc = 0;
    prev_hold = 1'b0; prev_dat = '0; fired = 1'b0;
    while (recv < 1000 && cyc < 40000) begin
      @(posedge clk); #1;
      cyc++;
      if (fired) begin
        if8.in_valid = 1'b0;
        fired = 1'b0;
      end
      if8.out_ready = ($urandom_range(0, 2) != 0);
      if (!if8.in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        if8.in_valid = 1'b1;
        if8.in_data  = {$urandom, $urandom};
        if8.in_desc  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (prev_hold) begin
        checks++; if (if8.out_valid !== 1'b1) begin errors++; $display("FAIL rnd_hold_valid cyc %0d got %b want 1", cyc, if8.out_valid); end
        checks++; if (if8.out_data !== prev_dat) begin errors++; $display("FAIL rnd_hold_data cyc %0d got %h want %h", cyc, if8.out_data, prev_dat); end
      end
      if (if8.out_valid && if8.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_extra_output got %h want none", if8.out_data);
        end else begin
          want = exp_q.pop_front();
          checks++; if (if8.out_data !== want) begin errors++; $display("FAIL rnd_data vec %0d got %h want %h", recv, if8.out_data, want); end
        end
        recv++;
      end
      prev_hold = if8.out_valid && !if8.out_ready;
      prev_dat  = if8.out_data;
      if (if8.in_valid && if8.in_ready) begin
        exp_q.push_back(ref_sort8(if8.in_data, if8.in_desc));
        sent++;
        fired = 1'b1;
      end
    end
    @(posedge clk); #1;
    if8.in_valid  = 1'b0;
    if8.out_ready = 1'b0;
    checks++; if (recv !== 1000) begin errors++; $display("FAIL rnd_recv_count got %0d want 1000", recv); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rnd_pending got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.in_desc = 1'b0; if4.out_ready = 1'b0;
    if8.in_valid = 1'b0; if8.in_data = '0; if8.in_desc = 1'b0; if8.out_ready = 1'b0;
    test_reset();
    test_ascending();
    test_descending();
    test_worst_and_dups();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sort_oet.md
# sort_oet

Parametrised, sequential successor to the 4×4-bit combinational sorting network. Sorts N unsigned W-bit lanes with an odd-even transposition network: one compare-exchange phase per clock, using a single bank of N/2 shared comparators. Input and output use valid/ready handshakes, and the sort order (ascending/descending) is selectable per vector. It sits between a vector producer and consumer wherever the combinational sorter's fixed 4×4 shape or its critical path is too limiting.

## Interface
- N, default 4: lane count; even, ≥2.
- W, default 4: lane width in bits, unsigned.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  in_data/in_desc valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_data  in  N*W  lane k = in_data[k*W +: W].
- in_desc  in  1  0 = ascending (lane 0 smallest, lane N-1 largest); 1 = descending.
- out_valid  out  1  out_data holds a sorted vector.
- out_ready  in  1  consumer takes out_data this cycle.
- out_data  out  N*W  sorted lanes, same lane layout as in_data.

## Operation
- FSM states: IDLE, SORT, DONE.
  - IDLE → SORT on in_valid && in_ready.
  - SORT → DONE after N phases.
  - DONE → IDLE on out_ready && !in_valid.
  - DONE → SORT on out_ready && in_valid (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational path from out_ready; no other combinational input→output path.
- Acceptance:
  - latches in_data into lane registers and in_desc into the mode register;
  - clears the phase counter (width $clog2(N)+1).
- Each SORT cycle applies one phase p:
  - p even: compare-exchange pairs (0,1),(2,3),…
  - p odd: compare-exchange pairs (1,2),(3,4),…; lanes 0 and N-1 pass through.
  - Counter then increments; after p = N-1, go to DONE.
- Compare-exchange: ascending swaps when lo > hi; descending swaps when lo < hi. Equal values never swap, so the sort is stable.
- Comparisons are unsigned, W bits; no width extension.
- out_data is driven directly from the lane registers. It is valid only while out_valid=1 and is held stable in DONE until out_ready.
- in_valid while busy (SORT, or DONE without out_ready) is ignored; the producer must hold its data.
- in_desc is sampled only at acceptance. Changes mid-sort have no effect.

## Timing
- Reset (async assert, async clear): state=IDLE, lanes=0, counter=0, mode=0, out_valid=0, in_ready=1, out_data=0.
- Reset mid-SORT or mid-DONE aborts the vector; no partial output appears.
- Latency: accept at edge k → phases at edges k+1…k+N → out_valid=1 from edge k+N. Total N cycles, fixed and independent of data.
- Throughput with out_ready held high: one vector per N+1 cycles (N SORT + 1 DONE/accept).
- out_valid = (state==DONE). A handshake at edge j drops out_valid after j unless a new vector is accepted at the same edge. Either way, out_valid is 0 for the following N cycles.

## Structure
- Package sort_pkg:
  - typedef enum logic [1:0] {IDLE, SORT, DONE} sort_state_t;
  - localparam helpers for the counter width.
- Sub-module cmp_swap (param W; inputs a, b, desc; outputs lo, hi): purely combinational, instantiated N/2 times.
  - Per-cycle wiring selects even or odd pairing by the phase parity.
  - Odd phases use N/2-1 of the instances.

## Test plan
- N=4, W=4, in_data=16'h3A17, in_desc=0 → out_valid exactly 4 cycles after acceptance, out_data=16'hA731.
- Same input with in_desc=1 → out_data=16'h137A.
- Worst case 16'h0123, ascending → 16'h3210 after exactly 4 phases. Duplicates 16'h5525 → 16'h5552.
- out_ready held low 10 cycles in DONE → out_data and out_valid stable, in_ready=0, in_valid pulses ignored. Releasing out_ready with in_valid=1 accepts the next vector on the same edge.
- Assert rst two cycles into SORT → all outputs 0 and in_ready=1 immediately. The next vector 16'h3A17 sorts correctly to 16'hA731.
- N=8, W=8, 1000 random vectors with random in_desc and random out_ready → every output matches the reference model: sorted, stable, no lost or duplicated vectors.
